sum_recover_div: RTL
====================

Name: sum_recover_div

Overview:
- Inverse of the (a+b)*c datapath: given result y, multiplier c and operand a, recovers b = (y / c) - a.
- Also reports the division remainder and an exact flag.
- Sequential radix-2 restoring divider behind valid/ready handshakes.
- Sits downstream of my_design as the decode/check end of the same interface; a scoreboard or self-check path uses it to confirm results.

Parameters:
WIDTH, 32, operand/result width in bits (applies to all data ports).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
y  input  WIDTH  forward-path result (dividend), unsigned.
c  input  WIDTH  forward-path multiplier (divisor), unsigned.
a  input  WIDTH  known first operand.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
b_out  output  WIDTH  recovered operand: (y / c - a) mod 2^WIDTH.
rem_out  output  WIDTH  y mod c.
exact  output  1  1 when rem_out == 0 and c != 0.
div_by_zero  output  1  1 when c == 0 for this request.

Behaviour:
- Reset values (async assert, sync release): state IDLE, in_ready=1, out_valid=0, b_out=0, rem_out=0, exact=0, div_by_zero=0, internal regs cleared.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - Handshake on in_valid & in_ready: capture y, c, a; clear quotient and partial remainder; count = WIDTH.
  - If c == 0, go to DONE, else go to DIV.
- DIV:
  - in_ready=0.
  - Each cycle: rem = {rem[WIDTH-2:0], dividend MSB}; shift dividend left.
  - If rem >= c: rem -= c, quotient bit = 1; else quotient bit = 0.
  - Decrement count; after exactly WIDTH iterations go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - b_out = quotient - a_captured, mod 2^WIDTH (wraps, no saturation).
  - rem_out = rem; exact = (rem == 0); div_by_zero = 0.
  - c == 0 case: b_out = 0, rem_out = y_captured, exact = 0, div_by_zero = 1.
  - Hold all outputs stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE and drop out_valid next cycle.
- Latency, measured from the accept edge:
  - Normal request: out_valid high WIDTH+1 cycles later (33 for WIDTH=32).
  - c == 0: out_valid high 1 cycle later.
- Throughput: one request in flight. No new accept until the DONE handshake has completed and the block is back in IDLE.
- Boundary conditions:
  - y < c: quotient 0, rem = y.
  - c == 1: quotient = y, rem = 0.
  - y == 0: quotient 0, exact = 1.
  - All-ones operands are handled unsigned.
  - in_valid held high during DIV/DONE is ignored and the inputs are not re-sampled.
  - Reset mid-operation (DIV or DONE): immediate return to reset values; the in-flight result is discarded with no out_valid pulse.
- All data paths are unsigned; no signed interpretation.

Decomposition:
- Shared package sum_recover_pkg:
  - state enum (IDLE, DIV, DONE);
  - default WIDTH constant;
  - a function for the trial-subtract step.
- One natural sub-module, seq_divider_core:
  - iterative restoring divider with start/busy/done, quotient and remainder.
  - The top holds the FSM, handshakes, the a-subtraction and the flags.

Test Plan:
- y=90, c=3, a=10 -> after 33 cycles: b_out=20, rem_out=0, exact=1, div_by_zero=0.
- y=300, c=2, a=100 -> b_out=50, exact=1. Then y=2, c=1, a=1 -> b_out=1, exact=1 (back-to-back, out_ready=1).
- Wrap case: y=0, c=5, a=32'hFFFFFFFF -> b_out=1, rem_out=0, exact=1. Also y=91, c=3, a=10 -> b_out=20, rem_out=1, exact=0.
- c=0, y=77, a=4 -> out_valid 1 cycle after accept; div_by_zero=1, b_out=0, rem_out=77, exact=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is not accepted. Release out_ready -> one handshake, then in_ready=1.
- Assert rst_n=0 at cycle 15 of DIV -> all outputs at reset values immediately. After release, a new request y=90, c=3, a=10 completes correctly with no stale result.

Source files
------------

// File: rtl/sum_recover_pkg.sv
// Shared types and helpers for the sum_recover_div decode/check path.
// Holds the FSM state type, default width and the divider trial-subtract step.
package sum_recover_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int MAX_W     = 64;

    // Returns {ge, r - d} when r >= d, else {0, r}.
    function automatic logic [MAX_W+1:0] trial_sub(
        input logic [MAX_W:0] r,
        input logic [MAX_W:0] d
    );
        logic ge;
        ge = (r >= d);
        return {ge, (ge ? r - d : r)};
    endfunction

endpackage

// File: rtl/seq_divider_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Quotient and remainder hold their values until the next start.
module seq_divider_core
    import sum_recover_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    // Shifted remainder keeps one extra bit so divisors above 2^(W-1) work.
    logic [WIDTH:0]   w_trial;
    logic [MAX_W+1:0] w_step;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;

    assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
    assign w_step    = trial_sub((MAX_W+1)'(w_trial), (MAX_W+1)'(r_dsr));
    assign w_qbit    = w_step[MAX_W+1] & ~|w_step[MAX_W:WIDTH];
    assign w_rem_nxt = w_step[WIDTH-1:0];

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CW'(1));
    assign o_quot = r_quot;
    assign o_rem  = r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_dvd  <= i_dividend;
            r_dsr  <= i_divisor;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= CW'(WIDTH);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
            r_quot <= {r_quot[WIDTH-2:0], w_qbit};
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sum_recover_div.sv
// Recovers b = y / c - a from the (a+b)*c forward path, with remainder,
// exact and divide-by-zero flags, behind valid/ready handshakes.
module sum_recover_div
    import sum_recover_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             exact,
    output logic             div_by_zero
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_a;
    logic             r_dz;

    logic             w_accept;
    logic             w_c_zero;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_c_zero = (c == '0);
    assign w_accept = in_valid & in_ready;

    seq_divider_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_accept & ~w_c_zero),
        .i_dividend(y),
        .i_divisor (c),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_quot    (w_quot),
        .o_rem     (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_a     <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_y  <= y;
                r_a  <= a;
                r_dz <= w_c_zero;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        b_out       = '0;
        rem_out     = '0;
        exact       = 1'b0;
        div_by_zero = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = ~w_busy;
                if (in_valid && !w_busy) begin
                    w_next = w_c_zero ? DONE : DIV;
                end
            end
            DIV: begin
                if (w_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (r_dz) begin
                    rem_out     = r_y;
                    div_by_zero = 1'b1;
                end else begin
                    b_out   = w_quot - r_a;
                    rem_out = w_rem;
                    exact   = (w_rem == '0);
                end
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
